// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: owns the machine-mode CSR file port and shares it between
// pipeline CSR accesses and the trap-entry / mret read-modify-write sequencer.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   csr_req_i/we_i/addr_i/wdata_i pipeline CSR request (held until granted)
//   csr_gnt_o                     pipeline request accepted this cycle
//   csr_rvalid_o, csr_rdata_o     pipeline read data pulse
//   exc_req_i, exc_cause_i/pc_i   trap request (level, held until redirect)
//   mret_i                        mret request (level, held until redirect)
//   redirect_valid_o/pc_o         one-cycle fetch redirect
//   busy_o                        sequencer not idle
//   csr_addr_o/we_o/re_o/wdata_o  CSR file port
//   csr_rdata_i                   CSR file read data, CSR_RD_LAT cycles after re
module csr_trap_ctrl #(
  parameter int unsigned CSR_RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_req_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_gnt_o,
  output logic        csr_rvalid_o,
  output logic [31:0] csr_rdata_o,
  input  logic        exc_req_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic        mret_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o,
  output logic [31:0] csr_addr_o,
  output logic        csr_we_o,
  output logic        csr_re_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i
);

  localparam int unsigned CNT_W = (CSR_RD_LAT > 1) ? $clog2(CSR_RD_LAT) : 1;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [3:0] {
    IDLE,
    P_WAIT,
    RD_ST,
    WT_ST,
    WR_EPC,
    WR_CAUSE,
    WR_ST,
    RD_TVEC,
    WT_TVEC,
    RD_EPC,
    WT_EPC,
    REDIRECT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mret_q;
  logic [31:0]        cause_q;
  logic [31:0]        pc_q;
  logic [31:0]        mstatus_q;
  logic [31:0]        target_q;

  logic               wait_done;
  logic               accept_exc, accept_mret, load_st, load_tgt;
  logic [31:0]        tgt_d;
  logic [31:0]        st_trap, st_mret;
  logic [31:0]        tvec_base, tvec_tgt;

  logic               gnt_c, rvalid_c, we_c, re_c, redirect_c;
  logic [31:0]        rdata_c, wdata_c;
  logic [11:0]        addr_c;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Captured trap context, mstatus snapshot and redirect target
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mret_q    <= 1'b0;
      cause_q   <= '0;
      pc_q      <= '0;
      mstatus_q <= '0;
      target_q  <= '0;
    end else begin
      if (accept_exc) begin
        mret_q  <= 1'b0;
        cause_q <= exc_cause_i;
        pc_q    <= exc_pc_i;
      end
      if (accept_mret) begin
        mret_q <= 1'b1;
      end
      if (load_st) begin
        mstatus_q <= csr_rdata_i;
      end
      if (load_tgt) begin
        target_q <= tgt_d;
      end
    end
  end

  // mstatus updates: trap stacks MIE into MPIE, mret restores it; MPP stays M
  always_comb begin
    st_trap         = mstatus_q;
    st_trap[7]      = mstatus_q[3];
    st_trap[3]      = 1'b0;
    st_trap[12:11]  = 2'b11;
    st_mret         = mstatus_q;
    st_mret[3]      = mstatus_q[7];
    st_mret[7]      = 1'b1;
    st_mret[12:11]  = 2'b11;
  end

  // Trap vector: vectored offset only for interrupts in mode 1
  always_comb begin
    tvec_base = {csr_rdata_i[31:2], 2'b00};
    tvec_tgt  = tvec_base;
    if ((csr_rdata_i[1:0] == 2'b01) && cause_q[31]) begin
      tvec_tgt = tvec_base + {cause_q[29:0], 2'b00};
    end
  end

  assign wait_done = (cnt_q == CNT_W'(CSR_RD_LAT - 1));

  // Next-state, port drive and capture strobes
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_c       = 1'b0;
    rvalid_c    = 1'b0;
    rdata_c     = '0;
    we_c        = 1'b0;
    re_c        = 1'b0;
    addr_c      = '0;
    wdata_c     = '0;
    redirect_c  = 1'b0;
    accept_exc  = 1'b0;
    accept_mret = 1'b0;
    load_st     = 1'b0;
    load_tgt    = 1'b0;
    tgt_d       = target_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (exc_req_i) begin
          accept_exc = 1'b1;
          state_d    = RD_ST;
        end else if (mret_i) begin
          accept_mret = 1'b1;
          state_d     = RD_ST;
        end else if (csr_req_i) begin
          gnt_c  = 1'b1;
          addr_c = csr_addr_i;
          if (csr_we_i) begin
            we_c    = 1'b1;
            wdata_c = csr_wdata_i;
          end else begin
            re_c    = 1'b1;
            state_d = P_WAIT;
          end
        end
      end
      P_WAIT: begin
        if (wait_done) begin
          rvalid_c = 1'b1;
          rdata_c  = csr_rdata_i;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_ST: begin
        re_c    = 1'b1;
        addr_c  = ADDR_MSTATUS;
        cnt_d   = '0;
        state_d = WT_ST;
      end
      WT_ST: begin
        if (wait_done) begin
          load_st = 1'b1;
          cnt_d   = '0;
          state_d = mret_q ? WR_ST : WR_EPC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_EPC: begin
        we_c    = 1'b1;
        addr_c  = ADDR_MEPC;
        wdata_c = {pc_q[31:2], 2'b00};
        state_d = WR_CAUSE;
      end
      WR_CAUSE: begin
        we_c    = 1'b1;
        addr_c  = ADDR_MCAUSE;
        wdata_c = cause_q;
        state_d = WR_ST;
      end
      WR_ST: begin
        we_c    = 1'b1;
        addr_c  = ADDR_MSTATUS;
        wdata_c = mret_q ? st_mret : st_trap;
        state_d = mret_q ? RD_EPC : RD_TVEC;
      end
      RD_TVEC: begin
        re_c    = 1'b1;
        addr_c  = ADDR_MTVEC;
        cnt_d   = '0;
        state_d = WT_TVEC;
      end
      WT_TVEC: begin
        if (wait_done) begin
          load_tgt = 1'b1;
          tgt_d    = tvec_tgt;
          cnt_d    = '0;
          state_d  = REDIRECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_EPC: begin
        re_c    = 1'b1;
        addr_c  = ADDR_MEPC;
        cnt_d   = '0;
        state_d = WT_EPC;
      end
      WT_EPC: begin
        if (wait_done) begin
          load_tgt = 1'b1;
          tgt_d    = {csr_rdata_i[31:2], 2'b00};
          cnt_d    = '0;
          state_d  = REDIRECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REDIRECT: begin
        redirect_c = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decoded port outputs are forced low while reset is asserted
  assign csr_gnt_o        = gnt_c & ~rst_i;
  assign csr_rvalid_o     = rvalid_c & ~rst_i;
  assign csr_rdata_o      = rst_i ? 32'h0 : rdata_c;
  assign csr_we_o         = we_c & ~rst_i;
  assign csr_re_o         = re_c & ~rst_i;
  assign csr_addr_o       = rst_i ? 32'h0 : {20'h0, addr_c};
  assign csr_wdata_o      = rst_i ? 32'h0 : wdata_c;
  assign redirect_valid_o = redirect_c & ~rst_i;
  assign redirect_pc_o    = target_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl with a behavioural CSR file and a
// rule-level reference model of trap entry, mret and redirect targets.
module tb_csr_trap_ctrl;

  localparam int unsigned LAT      = 1;
  localparam int unsigned EXC_CYC  = 6 + 2 * LAT;
  localparam int unsigned MRET_CYC = 4 + 2 * LAT;

  logic        clk_i;
  logic        rst_i;
  logic        csr_req_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic        csr_gnt_o;
  logic        csr_rvalid_o;
  logic [31:0] csr_rdata_o;
  logic        exc_req_i;
  logic [31:0] exc_cause_i;
  logic [31:0] exc_pc_i;
  logic        mret_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;
  logic [31:0] csr_addr_o;
  logic        csr_we_o;
  logic        csr_re_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i;

  int n_vec = 0;
  int n_err = 0;

  csr_trap_ctrl #(.CSR_RD_LAT(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .csr_req_i(csr_req_i), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_gnt_o(csr_gnt_o),
    .csr_rvalid_o(csr_rvalid_o), .csr_rdata_o(csr_rdata_o),
    .exc_req_i(exc_req_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
    .mret_i(mret_i), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .busy_o(busy_o),
    .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o), .csr_re_o(csr_re_o),
    .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural CSR file: write on the clock, read data LAT cycles after re
  logic [31:0] mem [4096];
  logic [31:0] rd_pipe [LAT];

  always @(posedge clk_i) begin
    if (csr_we_o) mem[csr_addr_o[11:0]] <= csr_wdata_o;
    rd_pipe[0] <= csr_re_o ? mem[csr_addr_o[11:0]] : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign csr_rdata_i = rd_pipe[LAT-1];

  // Reference model, written from the architectural rules
  function automatic logic [31:0] model_trap_st(input logic [31:0] st);
    logic [31:0] mie;
    mie = (st >> 3) & 32'd1;
    return (st & ~32'h0000_0088) | (mie << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] model_mret_st(input logic [31:0] st);
    logic [31:0] mpie;
    mpie = (st >> 7) & 32'd1;
    return (st & ~32'h0000_0008) | (mpie << 3) | 32'h0000_0080 | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] model_trap_pc(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base, off;
    base = mtvec - (mtvec % 32'd4);
    if ((mtvec % 32'd4) == 32'd1 && cause >= 32'h8000_0000) begin
      off = cause - 32'h8000_0000;
      return base + off * 32'd4;
    end
    return base;
  endfunction

  function automatic logic [31:0] align4(input logic [31:0] v);
    return v - (v % 32'd4);
  endfunction

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_req_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = a; csr_wdata_i = d;
    #1;
    n_vec++;
    if (csr_gnt_o !== 1'b1 || csr_we_o !== 1'b1 || csr_re_o !== 1'b0 ||
        csr_addr_o !== {20'h0, a} || csr_wdata_o !== d) begin
      n_err++;
      $display("FAIL pipe_write a=%h: gnt=%b we=%b re=%b addr=%h wdata=%h, want 1 1 0 %h %h",
               a, csr_gnt_o, csr_we_o, csr_re_o, csr_addr_o, csr_wdata_o, {20'h0, a}, d);
    end
    @(negedge clk_i);
    csr_req_i = 1'b0; csr_we_i = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, input logic [31:0] exp_d);
    csr_req_i = 1'b1; csr_we_i = 1'b0; csr_addr_i = a;
    #1;
    n_vec++;
    if (csr_gnt_o !== 1'b1 || csr_re_o !== 1'b1 || csr_we_o !== 1'b0 ||
        csr_addr_o !== {20'h0, a}) begin
      n_err++;
      $display("FAIL pipe_read_gnt a=%h: gnt=%b re=%b we=%b addr=%h, want 1 1 0 %h",
               a, csr_gnt_o, csr_re_o, csr_we_o, csr_addr_o, {20'h0, a});
    end
    for (int k = 1; k <= int'(LAT) + 2; k++) begin
      @(negedge clk_i);
      n_vec++;
      if (csr_rvalid_o !== (k == int'(LAT))) begin
        n_err++;
        $display("FAIL pipe_rvalid a=%h cycle %0d: got %b want %b", a, k, csr_rvalid_o, k == int'(LAT));
      end
      if (k == int'(LAT) && csr_rdata_o !== exp_d) begin
        n_err++;
        $display("FAIL pipe_rdata a=%h: got %h want %h", a, csr_rdata_o, exp_d);
      end
      if (k == 1) csr_req_i = 1'b0;
    end
  endtask

  // Run one trap or mret from acceptance to redirect; leaves the bench at the
  // negedge of the cycle after REDIRECT.
  task automatic run_seq(input bit is_mret, input logic [31:0] cause, input logic [31:0] pc,
                         input logic [31:0] exp_pc);
    int cyc;
    int want;
    cyc  = 0;
    want = is_mret ? int'(MRET_CYC) : int'(EXC_CYC);
    if (is_mret) mret_i = 1'b1; else exc_req_i = 1'b1;
    exc_cause_i = cause; exc_pc_i = pc;
    #1;
    n_vec++;
    if (busy_o !== 1'b0 || csr_gnt_o !== 1'b0) begin
      n_err++;
      $display("FAIL accept_cycle mret=%0d: busy=%b gnt=%b want 0 0", is_mret, busy_o, csr_gnt_o);
    end
    @(negedge clk_i);
    exc_cause_i = $urandom(); exc_pc_i = $urandom();
    for (int k = 1; k <= 40; k++) begin
      n_vec++;
      if (busy_o !== 1'b1 || csr_gnt_o !== 1'b0 || (csr_we_o === 1'b1 && csr_re_o === 1'b1)) begin
        n_err++;
        $display("FAIL seq_cycle mret=%0d k=%0d: busy=%b gnt=%b we=%b re=%b want busy=1 gnt=0 not(we&re)",
                 is_mret, k, busy_o, csr_gnt_o, csr_we_o, csr_re_o);
      end
      if (redirect_valid_o === 1'b1) begin
        cyc = k;
        break;
      end
      @(negedge clk_i);
    end
    n_vec++;
    if (cyc != want) begin
      n_err++;
      $display("FAIL redirect_latency mret=%0d: got C0+%0d want C0+%0d", is_mret, cyc, want);
    end
    n_vec++;
    if (redirect_pc_o !== exp_pc) begin
      n_err++;
      $display("FAIL redirect_pc mret=%0d: got %h want %h", is_mret, redirect_pc_o, exp_pc);
    end
    if (is_mret) mret_i = 1'b0; else exc_req_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if (redirect_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL after_redirect mret=%0d: redirect=%b busy=%b want 0 0", is_mret, redirect_valid_o, busy_o);
    end
  endtask

  task automatic check_mem(input string name, input logic [11:0] a, input logic [31:0] exp_d);
    n_vec++;
    if (mem[a] !== exp_d) begin
      n_err++;
      $display("FAIL %s csr[%h]: got %h want %h", name, a, mem[a], exp_d);
    end
  endtask

  task automatic do_trap(input logic [31:0] st, input logic [31:0] tvec,
                         input logic [31:0] cause, input logic [31:0] pc);
    csr_write(12'h300, st);
    csr_write(12'h305, tvec);
    run_seq(1'b0, cause, pc, model_trap_pc(tvec, cause));
    check_mem("trap_mepc", 12'h341, align4(pc));
    check_mem("trap_mcause", 12'h342, cause);
    check_mem("trap_mstatus", 12'h300, model_trap_st(st));
  endtask

  task automatic do_mret(input logic [31:0] st, input logic [31:0] epc);
    csr_write(12'h300, st);
    csr_write(12'h341, epc);
    run_seq(1'b1, 32'h0, 32'h0, align4(epc));
    check_mem("mret_mstatus", 12'h300, model_mret_st(st));
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    csr_req_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = 12'h305; csr_wdata_i = 32'h1234_5678;
    exc_req_i = 1'b0; mret_i = 1'b0; exc_cause_i = '0; exc_pc_i = '0;
    repeat (2) @(negedge clk_i);
    n_vec++;
    if (csr_gnt_o !== 1'b0 || csr_we_o !== 1'b0 || csr_re_o !== 1'b0 || busy_o !== 1'b0 ||
        redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'h0 || csr_rvalid_o !== 1'b0 ||
        csr_addr_o !== 32'h0 || csr_wdata_o !== 32'h0 || csr_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: gnt=%b we=%b re=%b busy=%b rv=%b rpc=%h addr=%h wd=%h, want all 0",
               csr_gnt_o, csr_we_o, csr_re_o, busy_o, redirect_valid_o, redirect_pc_o, csr_addr_o, csr_wdata_o);
    end
    csr_req_i = 1'b0; csr_we_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_pipeline();
    logic [11:0] a;
    logic [31:0] d;
    csr_write(12'h305, 32'h0000_1000);
    csr_read(12'h305, 32'h0000_1000);
    for (int i = 0; i < 6; i++) begin
      a = 12'($urandom());
      d = $urandom();
      csr_write(a, d);
      csr_read(a, d);
    end
  endtask

  task automatic test_direct_exc();
    do_trap(32'h0000_0008, 32'h0000_1000, 32'd2, 32'h0000_0206);
  endtask

  task automatic test_vectored();
    do_trap(32'h0000_0008, 32'h0000_1001, 32'h8000_0007, 32'h0000_0100);
    do_trap(32'h0000_0000, 32'h0000_1001, 32'd5, 32'h0000_0104);
    do_trap(32'h0000_0088, 32'h0000_2003, 32'h8000_000B, 32'h0000_0200);
  endtask

  task automatic test_mret();
    do_mret(32'h0000_1880, 32'h0000_0206);
    do_mret(32'h0000_0008, 32'hFFFF_FFFF);
  endtask

  task automatic test_random();
    logic [31:0] cause;
    for (int i = 0; i < 10; i++) begin
      cause = $urandom();
      if ($urandom_range(1, 0) == 0) cause = {cause[31], 26'h0, cause[4:0]};
      do_trap($urandom(), $urandom(), cause, $urandom());
      do_mret($urandom(), $urandom());
    end
  endtask

  task automatic test_contention();
    logic [31:0] st, tvec, pc, cause;
    st = 32'h0000_0008; tvec = 32'h0000_3001; cause = 32'h8000_0003; pc = 32'h0000_0456;
    csr_write(12'h300, st);
    csr_write(12'h305, tvec);
    csr_write(12'h340, 32'h0);
    mret_i = 1'b1;
    csr_req_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = 12'h340; csr_wdata_i = 32'hCAFE_F00D;
    run_seq(1'b0, cause, pc, model_trap_pc(tvec, cause));
    check_mem("cont_mstatus_trap", 12'h300, model_trap_st(st));
    run_seq(1'b1, 32'h0, 32'h0, align4(pc));
    check_mem("cont_mstatus_mret", 12'h300, model_mret_st(model_trap_st(st)));
    n_vec++;
    if (csr_gnt_o !== 1'b1 || csr_we_o !== 1'b1) begin
      n_err++;
      $display("FAIL cont_pipe_gnt: gnt=%b we=%b want 1 1", csr_gnt_o, csr_we_o);
    end
    @(negedge clk_i);
    csr_req_i = 1'b0; csr_we_i = 1'b0;
    check_mem("cont_pipe_write", 12'h340, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_mid();
    logic [31:0] st;
    st = 32'h0000_0008;
    csr_write(12'h300, st);
    csr_write(12'h305, 32'h0000_1000);
    csr_write(12'h342, 32'h0000_AAAA);
    exc_req_i = 1'b1; exc_cause_i = 32'd11; exc_pc_i = 32'h0000_0800;
    repeat (3 + LAT) @(negedge clk_i);
    n_vec++;
    if (csr_we_o !== 1'b1 || csr_addr_o !== 32'h0000_0342) begin
      n_err++;
      $display("FAIL mid_wr_cause: we=%b addr=%h want 1 00000342", csr_we_o, csr_addr_o);
    end
    rst_i = 1'b1; exc_req_i = 1'b0;
    #1;
    n_vec++;
    if (csr_we_o !== 1'b0 || csr_re_o !== 1'b0 || busy_o !== 1'b0 || redirect_valid_o !== 1'b0 ||
        redirect_pc_o !== 32'h0 || csr_addr_o !== 32'h0 || csr_wdata_o !== 32'h0 || csr_gnt_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: we=%b re=%b busy=%b rv=%b rpc=%h addr=%h wd=%h, want all 0",
               csr_we_o, csr_re_o, busy_o, redirect_valid_o, redirect_pc_o, csr_addr_o, csr_wdata_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      n_vec++;
      if (csr_we_o !== 1'b0 || redirect_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset k=%0d: we=%b redirect=%b busy=%b want 0 0 0",
                 k, csr_we_o, redirect_valid_o, busy_o);
      end
    end
    check_mem("mid_mcause_kept", 12'h342, 32'h0000_AAAA);
    check_mem("mid_mstatus_kept", 12'h300, st);
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_direct_exc();
    test_vectored();
    test_mret();
    test_random();
    test_contention();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Trap and CSR-port controller for the machine-mode CSR file. It owns the single CSR read/write port and shares it between pipeline CSR instructions and its own trap-entry and `mret` sequencer. On a trap it performs the required CSR read-modify-write sequence and produces the redirect PC for the fetch stage. It sits between decode/execute and the CSR file, and it is the only block that drives the CSR file's port.

## Interface
- `CSR_RD_LAT`, default 1: CSR file read latency in cycles (≥1). Read data is valid `CSR_RD_LAT` cycles after the cycle in which `csr_re_o` is asserted.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `csr_req_i` in 1: pipeline CSR access request, held until granted.
- `csr_we_i` in 1: pipeline request is a write (1) or a read (0).
- `csr_addr_i` in 12: pipeline CSR address.
- `csr_wdata_i` in 32: pipeline write data.
- `csr_gnt_o` out 1: pipeline request accepted this cycle.
- `csr_rvalid_o` out 1: one-cycle pulse; pipeline read data valid.
- `csr_rdata_o` out 32: pipeline read data.
- `exc_req_i` in 1: exception/interrupt request, level, held until `redirect_valid_o`.
- `exc_cause_i` in 32: mcause value; bit 31 set means interrupt.
- `exc_pc_i` in 32: faulting PC.
- `mret_i` in 1: mret request, level, held until `redirect_valid_o`.
- `redirect_valid_o` out 1: one-cycle pulse; `redirect_pc_o` is valid.
- `redirect_pc_o` out 32: new fetch PC.
- `busy_o` out 1: FSM is not in IDLE.
- `csr_addr_o` out 32: CSR file address, zero-extended 12-bit.
- `csr_we_o` out 1: CSR file write enable.
- `csr_re_o` out 1: CSR file read enable.
- `csr_wdata_o` out 32: CSR file write data.
- `csr_rdata_i` in 32: CSR file read data.

## Operation
- **CSR addresses:** mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
- **Port exclusivity:** `csr_we_o` and `csr_re_o` are never asserted together. Both are 0 in every state not listed below.
- **Arbitration in IDLE:** priority is `exc_req_i` > `mret_i` > `csr_req_i`. Grants are given only in IDLE. Pipeline requests that lose arbitration wait, with `csr_gnt_o` held at 0.
- **Capture on acceptance:** `exc_cause_i` and `exc_pc_i` are registered in the accept cycle, so later changes to them are ignored.
- **Pipeline write:** `csr_gnt_o`=1 and the port is driven combinationally in the IDLE cycle, with `csr_we_o`=1. The FSM stays in IDLE.
- **Pipeline read:** `csr_gnt_o`=1 and `csr_re_o`=1 in the IDLE cycle. The FSM then moves to P_WAIT for `CSR_RD_LAT` cycles. On the last P_WAIT cycle, `csr_rvalid_o`=1 and `csr_rdata_o`=`csr_rdata_i`, and the FSM returns to IDLE.
- **Exception path:** IDLE → RD_ST → WT_ST → WR_EPC → WR_CAUSE → WR_ST → RD_TVEC → WT_TVEC → REDIRECT → IDLE.
- **Mret path:** IDLE → RD_ST → WT_ST → WR_ST → RD_EPC → WT_EPC → REDIRECT → IDLE.
- **Wait states:** WT_* states last `CSR_RD_LAT` cycles. `csr_rdata_i` is captured on the last cycle.
- **Write data per state:**
  - WR_EPC writes `pc & ~3`.
  - WR_CAUSE writes the captured cause.
  - WR_ST (trap) writes the captured mstatus with bit7 ← bit3, bit3 ← 0, [12:11] ← 2'b11.
  - WR_ST (mret) writes the captured mstatus with bit3 ← bit7, bit7 ← 1, [12:11] ← 2'b11 (M-only hart).
- **Redirect target:**
  - Trap: with base = `{mtvec[31:2],2'b00}`, the target is base + 4·cause[30:0] if mtvec[1:0]==1 and cause[31]==1; otherwise base. mtvec[1:0] ≥ 2 is treated as direct mode. Arithmetic is modulo 2^32.
  - Mret: `mepc & ~3`.
  - The target is registered in WT_TVEC/WT_EPC.
- **REDIRECT state:** `redirect_valid_o`=1 for exactly one cycle. The requester drops its request in the following cycle; the FSM re-arbitrates in IDLE from that cycle on.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE.
- **Reset mid-operation:** the sequence is abandoned immediately. No further CSR writes are issued, and no redirect is produced.
- **Pipeline write:** 0 cycles; granted in the request cycle when no trap or mret is pending.
- **Pipeline read:** `csr_rvalid_o` at C0+`CSR_RD_LAT` (C0 = grant cycle).
- **Exception:** `redirect_valid_o` at C0+6+2·`CSR_RD_LAT` (C0 = accept cycle); C0+8 for latency 1.
- **Mret:** `redirect_valid_o` at C0+4+2·`CSR_RD_LAT`; C0+6 for latency 1.
- **Simultaneous `exc_req_i` and `mret_i`:** the exception runs; the mret stays pending.
- **`busy_o`:** 1 from C0+1 through the REDIRECT cycle inclusive.

## Test plan
- **Pipeline write/read (latency 1):** write 0x305=0x0000_1000; read 0x305 → grant same cycle; `csr_rvalid_o` 1 cycle later with `csr_rdata_o`=0x0000_1000.
- **Direct-mode exception:** mtvec=0x1000, mstatus=0x8, exception cause=2, pc=0x206 → mepc=0x204, mcause=2, mstatus=0x1880, `redirect_pc_o`=0x1000 at C0+8.
- **Vectored interrupt:** mtvec=0x1001, cause=0x8000_0007 → `redirect_pc_o`=0x101C. Same mtvec with cause=5 (exception) → 0x1000.
- **Mret:** mstatus=0x1880, mepc=0x206, `mret_i` → mstatus=0x1888, `redirect_pc_o`=0x204 at C0+6.
- **Three-way contention:** `exc_req_i`, `mret_i`, `csr_req_i` all raised in IDLE → exception sequence runs; `csr_gnt_o` stays 0 until IDLE; the mret runs next, then the pipeline request is granted.
- **Reset mid-sequence:** assert `rst_i` during WR_CAUSE → all outputs 0 at once; after release, FSM is in IDLE, no `csr_we_o` is seen, and `redirect_valid_o` never pulses.
